// File: rtl/imm_gen_pkg.sv
// Shared types and SPARC field encodings for the immediate generator.
package imm_gen_pkg;

  // Immediate class reported alongside every extended immediate.
  typedef enum logic [2:0] {
    KindNone   = 3'd0,
    KindReg    = 3'd1,
    KindSimm13 = 3'd2,
    KindShcnt  = 3'd3,
    KindTrap   = 3'd4,
    KindSethi  = 3'd5,
    KindBr22   = 3'd6,
    KindCall   = 3'd7
  } kind_e;

  // op field, IR[31:30]
  localparam logic [1:0] OP_BR    = 2'b00;
  localparam logic [1:0] OP_CALL  = 2'b01;
  localparam logic [1:0] OP_ARITH = 2'b10;
  localparam logic [1:0] OP_MEM   = 2'b11;

  // op2 field, IR[24:22]
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_FBFCC = 3'b110;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  // op3 field, IR[24:19]
  localparam logic [5:0] OP3_SLL  = 6'b100101;
  localparam logic [5:0] OP3_SRL  = 6'b100110;
  localparam logic [5:0] OP3_SRA  = 6'b100111;
  localparam logic [5:0] OP3_TICC = 6'b111010;

  // Only branches and CALL produce a PC-relative target.
  function automatic logic is_pc_rel(input kind_e kind);
    return (kind == KindBr22) || (kind == KindCall);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension for one instruction word.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [31:0]       ir_i,
  output kind_e             kind_o,
  output logic [DATA_W-1:0] imm_o
);

  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic       i_bit;

  // Sign-extended displacement / simm fields at full datapath width
  logic signed [DATA_W-1:0] disp22_sx;
  logic signed [DATA_W-1:0] disp30_sx;
  logic signed [DATA_W-1:0] simm13_sx;

  assign op    = ir_i[31:30];
  assign op2   = ir_i[24:22];
  assign op3   = ir_i[24:19];
  assign i_bit = ir_i[13];

  assign disp22_sx = DATA_W'($signed(ir_i[21:0]));
  assign disp30_sx = DATA_W'($signed(ir_i[29:0]));
  assign simm13_sx = DATA_W'($signed(ir_i[12:0]));

  // Classify the word and build the matching extended immediate
  always_comb begin
    kind_o = KindNone;
    imm_o  = '0;
    unique case (op)
      OP_BR: begin
        if ((op2 == OP2_BICC) || (op2 == OP2_FBFCC)) begin
          kind_o = KindBr22;
          imm_o  = disp22_sx << 2;
        end else if (op2 == OP2_SETHI) begin
          kind_o = KindSethi;
          imm_o  = DATA_W'({ir_i[21:0], 10'b0});
        end
      end
      OP_CALL: begin
        kind_o = KindCall;
        imm_o  = disp30_sx << 2;
      end
      default: begin
        // Shift and trap forms only exist in the arithmetic opcode space
        if (!i_bit) begin
          kind_o = KindReg;
        end else if ((op == OP_ARITH) &&
                     ((op3 == OP3_SLL) || (op3 == OP3_SRL) || (op3 == OP3_SRA))) begin
          kind_o = KindShcnt;
          imm_o  = DATA_W'(ir_i[4:0]);
        end else if ((op == OP_ARITH) && (op3 == OP3_TICC)) begin
          kind_o = KindTrap;
          imm_o  = DATA_W'(ir_i[6:0]);
        end else begin
          kind_o = KindSimm13;
          imm_o  = simm13_sx;
        end
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator with valid/ready backpressure and flush.
// Stage 1 holds the decoded immediate and PC; stage 2 adds the branch target.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 32  // must be at least 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [31:0]       IR,
  input  logic [DATA_W-1:0] PC,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Imm,
  output logic [DATA_W-1:0] Target,
  output kind_e             Kind
);

  kind_e             dec_kind;
  logic [DATA_W-1:0] dec_imm;

  logic              s1_valid_q, s1_valid_d;
  kind_e             s1_kind_q, s1_kind_d;
  logic [DATA_W-1:0] s1_imm_q, s1_imm_d;
  logic [DATA_W-1:0] s1_pc_q, s1_pc_d;

  logic              s2_valid_q, s2_valid_d;
  kind_e             s2_kind_q, s2_kind_d;
  logic [DATA_W-1:0] s2_imm_q, s2_imm_d;
  logic [DATA_W-1:0] s2_target_q, s2_target_d;

  logic s2_adv;
  logic in_fire;
  logic s1_fire;

  imm_decode #(
    .DATA_W (DATA_W)
  ) u_imm_decode (
    .ir_i   (IR),
    .kind_o (dec_kind),
    .imm_o  (dec_imm)
  );

  // Handshake: stage 2 moves when empty or drained; In_Ready never looks at In_Valid
  always_comb begin
    s2_adv   = !s2_valid_q || Out_Ready;
    In_Ready = !Flush && (!s1_valid_q || s2_adv);
    in_fire  = In_Valid && In_Ready;
    s1_fire  = s1_valid_q && s2_adv;
  end

  // Next-state for both stages; flush only clears valids, data is left as is
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_kind_d   = s1_kind_q;
    s1_imm_d    = s1_imm_q;
    s1_pc_d     = s1_pc_q;
    s2_valid_d  = s2_valid_q;
    s2_kind_d   = s2_kind_q;
    s2_imm_d    = s2_imm_q;
    s2_target_d = s2_target_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_kind_d  = dec_kind;
      s1_imm_d   = dec_imm;
      s1_pc_d    = PC;
    end else if (s1_fire) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_fire) begin
      s2_kind_d   = s1_kind_q;
      s2_imm_d    = s1_imm_q;
      s2_target_d = is_pc_rel(s1_kind_q) ? (s1_pc_q + s1_imm_q) : '0;
    end

    if (Flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_kind_q   <= KindNone;
      s1_imm_q    <= '0;
      s1_pc_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_kind_q   <= KindNone;
      s2_imm_q    <= '0;
      s2_target_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_kind_q   <= s1_kind_d;
      s1_imm_q    <= s1_imm_d;
      s1_pc_q     <= s1_pc_d;
      s2_valid_q  <= s2_valid_d;
      s2_kind_q   <= s2_kind_d;
      s2_imm_q    <= s2_imm_d;
      s2_target_q <= s2_target_d;
    end
  end

  assign Out_Valid = s2_valid_q;
  assign Kind      = s2_kind_q;
  assign Imm       = s2_imm_q;
  assign Target    = s2_target_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe at DATA_W=32 and DATA_W=64.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  typedef struct {
    kind_e       kind;
    logic [63:0] imm;
    logic [63:0] tgt;
  } exp_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  // 32-bit instance
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] ir, pc, imm, target;
  kind_e       kind;
  // 64-bit instance
  logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_ir;
  logic [63:0] w_pc, w_imm, w_target;
  kind_e       w_kind;

  exp_t q32[$];
  exp_t q64[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  imm_gen_pipe #(.DATA_W(32)) u_dut32 (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (flush),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .IR        (ir),
    .PC        (pc),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Imm       (imm),
    .Target    (target),
    .Kind      (kind)
  );

  imm_gen_pipe #(.DATA_W(64)) u_dut64 (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (w_flush),
    .In_Valid  (w_in_valid),
    .In_Ready  (w_in_ready),
    .IR        (w_ir),
    .PC        (w_pc),
    .Out_Valid (w_out_valid),
    .Out_Ready (w_out_ready),
    .Imm       (w_imm),
    .Target    (w_target),
    .Kind      (w_kind)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop the oldest expectation whenever an output transfer happens
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && out_valid && out_ready) begin
      if (q32.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out32_extra: got kind %0d imm 0x%0h, expected no output", kind, imm);
      end else begin
        e = q32.pop_front();
        check("kind32", 64'(kind), 64'(e.kind));
        check("imm32", 64'(imm), e.imm);
        check("target32", 64'(target), e.tgt);
      end
    end
  end

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && w_out_valid && w_out_ready) begin
      if (q64.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out64_extra: got kind %0d imm 0x%0h, expected no output", w_kind, w_imm);
      end else begin
        e = q64.pop_front();
        check("kind64", 64'(w_kind), 64'(e.kind));
        check("imm64", w_imm, e.imm);
        check("target64", w_target, e.tgt);
      end
    end
  end

  // Present one word, push its expectation at the accepting edge
  task automatic send32(input logic [31:0] i_ir, input logic [31:0] i_pc, input kind_e k,
                        input logic [31:0] e_imm, input logic [31:0] e_tgt);
    exp_t e;
    bit   done = 1'b0;
    e.kind   = k;
    e.imm    = {32'h0, e_imm};
    e.tgt    = {32'h0, e_tgt};
    ir       = i_ir;
    pc       = i_pc;
    in_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge Clk);
      if (in_ready) begin
        q32.push_back(e);
        done = 1'b1;
      end
      @(posedge Clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept32", 64'(done), 64'd1);
  endtask

  task automatic send64(input logic [31:0] i_ir, input logic [63:0] i_pc, input kind_e k,
                        input logic [63:0] e_imm, input logic [63:0] e_tgt);
    exp_t e;
    bit   done = 1'b0;
    e.kind     = k;
    e.imm      = e_imm;
    e.tgt      = e_tgt;
    w_ir       = i_ir;
    w_pc       = i_pc;
    w_in_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge Clk);
      if (w_in_ready) begin
        q64.push_back(e);
        done = 1'b1;
      end
      @(posedge Clk);
      #1;
    end
    w_in_valid = 1'b0;
    check("accept64", 64'(done), 64'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    Reset      = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ir         = '0;
    pc         = '0;
    w_flush    = 1'b0;
    w_in_valid = 1'b0;
    w_out_ready = 1'b1;
    w_ir       = '0;
    w_pc       = '0;
    cycles(3);
    Reset = 1'b0;

    // Reset state
    @(negedge Clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imm", 64'(imm), 64'd0);
    check("rst_target", 64'(target), 64'd0);
    check("rst_kind", 64'(kind), 64'(KindNone));
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid64", 64'(w_out_valid), 64'd0);
    @(posedge Clk);
    #1;

    // Streaming decode of every immediate class
    out_ready = 1'b1;
    send32(32'h10BFFFFF, 32'h100,  KindBr22,   32'hFFFFFFFC, 32'h000000FC);
    send32(32'h40000001, 32'h1000, KindCall,   32'h00000004, 32'h00001004);
    send32(32'h013FFFFF, 32'h2000, KindSethi,  32'hFFFFFC00, 32'h0);
    send32(32'h80003FFF, 32'h0,    KindSimm13, 32'hFFFFFFFF, 32'h0);
    send32(32'h81383FFF, 32'h0,    KindShcnt,  32'h0000001F, 32'h0);
    send32(32'h81282FE3, 32'h0,    KindShcnt,  32'h00000003, 32'h0);
    send32(32'h80001FFF, 32'h0,    KindReg,    32'h0,        32'h0);
    send32(32'h81D03FFF, 32'h0,    KindTrap,   32'h0000007F, 32'h0);
    send32(32'h00000123, 32'h0,    KindNone,   32'h0,        32'h0);
    send32(32'h01800002, 32'h200,  KindBr22,   32'h00000008, 32'h00000208);
    send32(32'hC0002005, 32'h300,  KindSimm13, 32'h00000005, 32'h0);
    send32(32'hC1382003, 32'h0,    KindSimm13, 32'h00000003, 32'h0);
    send32(32'h7FFFFFFF, 32'h0,    KindCall,   32'hFFFFFFFC, 32'hFFFFFFFC);
    cycles(4);

    // Backpressure: two entries fill the pipe, third waits, outputs hold
    out_ready = 1'b0;
    send32(32'h10BFFFFF, 32'h100,  KindBr22, 32'hFFFFFFFC, 32'h000000FC);
    send32(32'h40000001, 32'h1000, KindCall, 32'h00000004, 32'h00001004);
    fork
      send32(32'h80003FFF, 32'h0, KindSimm13, 32'hFFFFFFFF, 32'h0);
      begin
        repeat (3) begin
          @(negedge Clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
          check("stall_kind", 64'(kind), 64'(KindBr22));
          check("stall_imm", 64'(imm), 64'hFFFFFFFC);
          check("stall_target", 64'(target), 64'h000000FC);
        end
        @(posedge Clk);
        #1;
        out_ready = 1'b1;
      end
    join
    cycles(4);

    // Flush with both stages full and a pending input
    out_ready = 1'b0;
    send32(32'h10BFFFFF, 32'h100,  KindBr22, 32'hFFFFFFFC, 32'h000000FC);
    send32(32'h40000001, 32'h1000, KindCall, 32'h00000004, 32'h00001004);
    ir       = 32'h80003FFF;
    pc       = 32'h0;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge Clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge Clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    @(negedge Clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_refill_ready", 64'(in_ready), 64'd1);
    @(posedge Clk);
    #1;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check("flush_no_accept", 64'(out_valid), 64'd0);
    end
    @(posedge Clk);
    #1;

    // Reset with entries in flight, also outranking flush and input
    out_ready = 1'b0;
    send32(32'h10BFFFFF, 32'h100,  KindBr22, 32'hFFFFFFFC, 32'h000000FC);
    send32(32'h40000001, 32'h1000, KindCall, 32'h00000004, 32'h00001004);
    ir       = 32'h80003FFF;
    in_valid = 1'b1;
    flush    = 1'b1;
    Reset    = 1'b1;
    @(posedge Clk);
    #1;
    Reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    @(negedge Clk);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_imm", 64'(imm), 64'd0);
    check("mrst_target", 64'(target), 64'd0);
    check("mrst_kind", 64'(kind), 64'(KindNone));
    @(posedge Clk);
    #1;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check("mrst_no_accept", 64'(out_valid), 64'd0);
    end
    @(posedge Clk);
    #1;

    // Recovery after reset
    send32(32'h81383FFF, 32'h0, KindShcnt, 32'h0000001F, 32'h0);
    cycles(4);

    // Wide datapath
    send64(32'h7FFFFFFF, 64'h10,  KindCall,   64'hFFFFFFFFFFFFFFFC, 64'h000000000000000C);
    send64(32'h013FFFFF, 64'h0,   KindSethi,  64'h00000000FFFFFC00, 64'h0);
    send64(32'h80003FFF, 64'h0,   KindSimm13, 64'hFFFFFFFFFFFFFFFF, 64'h0);
    send64(32'h10BFFFFF, 64'h100, KindBr22,   64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC);
    cycles(5);

    check("drain32", 64'(q32.size()), 64'd0);
    check("drain64", 64'(q64.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
